// File: rtl/core101_pkg.sv
// Shared defaults and fetch FSM state encodings for the core101 front end.
package core101_pkg;

  localparam int          ADDR_WIDTH_DEF = 32;
  localparam int          INS_WIDTH_DEF  = 32;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
  localparam int          PC_STEP_DEF    = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  // Both REQ and DROP keep a read outstanding on the memory port.
  function automatic logic is_busy(input logic [1:0] st);
    return (st == REQ) || (st == DROP);
  endfunction

endpackage

// File: rtl/fq_fifo_mem.sv
// Storage for the fetch queue: DEPTH entries, head exposed combinationally, flushable.
module fq_fifo_mem #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       push_data,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  // Popping an empty queue or pushing a full one is silently ignored.
  assign do_push = push & ~flush & (count_reg != CW'(DEPTH));
  assign do_pop  = pop & ~flush & (count_reg != '0);

  always_ff @(posedge clk) begin
    if (srst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_data;
  end

  assign head_data = mem_reg[rd_ptr_reg];
  assign count     = count_reg;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: sequential PC generation, one-outstanding memory reads,
// and a decoupling queue towards decode with halt and branch-redirect flush.
module fetch_queue
  import core101_pkg::*;
#(
  parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int                    INS_WIDTH  = INS_WIDTH_DEF,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEF),
  parameter int                    PC_STEP    = PC_STEP_DEF
) (
  input  logic                   clock_in,
  input  logic                   reset_in,
  input  logic                   halt_in,
  input  logic                   redirect_valid_in,
  input  logic [ADDR_WIDTH-1:0]  redirect_addr_in,
  output logic [ADDR_WIDTH-1:0]  mem_addr_out,
  output logic                   mem_read_out,
  input  logic                   mem_valid_in,
  input  logic [INS_WIDTH-1:0]   mem_data_in,
  output logic                   dec_valid_out,
  output logic [INS_WIDTH-1:0]   dec_ins_out,
  output logic [ADDR_WIDTH-1:0]  dec_pc_out,
  input  logic                   dec_ready_in,
  output logic [$clog2(DEPTH):0] fq_count_out
);

  localparam int            CW   = $clog2(DEPTH) + 1;
  localparam int            EW   = ADDR_WIDTH + INS_WIDTH;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [1:0]            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] fetch_pc_reg, fetch_pc_next;
  logic [ADDR_WIDTH-1:0] drop_addr_reg;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_after_pop;
  logic [CW-1:0]         count_after_push;
  logic [EW-1:0]         head_data;
  logic                  push;
  logic                  pop;

  // A redirect wins over everything, so it masks both queue operations this cycle.
  assign pop  = (count != '0) & dec_ready_in & ~redirect_valid_in;
  assign push = (state_reg == REQ) & mem_valid_in & ~redirect_valid_in;

  assign count_after_pop  = count - CW'(pop);
  assign count_after_push = count_after_pop + CW'(push);

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    if (redirect_valid_in) begin
      fetch_pc_next = redirect_addr_in;
      case (state_reg)
        REQ, DROP: state_next = mem_valid_in ? IDLE : DROP;
        default:   state_next = IDLE;
      endcase
    end else begin
      case (state_reg)
        IDLE: if (!halt_in && (count_after_pop < FULL)) state_next = REQ;
        REQ: begin
          if (mem_valid_in) begin
            fetch_pc_next = fetch_pc_reg + ADDR_WIDTH'(PC_STEP);
            state_next    = (!halt_in && (count_after_push < FULL)) ? REQ : IDLE;
          end
        end
        DROP: if (mem_valid_in) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_reg     <= IDLE;
      fetch_pc_reg  <= RESET_PC;
      drop_addr_reg <= RESET_PC;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      if (redirect_valid_in && (state_reg == REQ)) drop_addr_reg <= fetch_pc_reg;
    end
  end

  // fetch_pc already points at the redirect target while the stale read drains,
  // so the abandoned address is replayed on the bus to keep it stable.
  assign mem_addr_out  = (state_reg == DROP) ? drop_addr_reg : fetch_pc_reg;
  assign mem_read_out  = is_busy(state_reg);
  assign dec_valid_out = (count != '0);
  assign {dec_pc_out, dec_ins_out} = head_data;
  assign fq_count_out  = count;

  fq_fifo_mem #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clock_in),
    .srst      (reset_in),
    .flush     (redirect_valid_in),
    .push      (push),
    .pop       (pop),
    .push_data ({fetch_pc_reg, mem_data_in}),
    .head_data (head_data),
    .count     (count)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: the bench plays instruction memory and decode,
// a queue-based reference model predicts the decode stream and request behaviour.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic        clock_in = 1'b0;
  logic        reset_in;
  logic        halt_in;
  logic        redirect_valid_in;
  logic [31:0] redirect_addr_in;
  logic [31:0] mem_addr_out;
  logic        mem_read_out;
  logic        mem_valid_in;
  logic [31:0] mem_data_in;
  logic        dec_valid_out;
  logic [31:0] dec_ins_out;
  logic [31:0] dec_pc_out;
  logic        dec_ready_in;
  logic [2:0]  fq_count_out;

  fetch_queue #(
    .ADDR_WIDTH (32),
    .INS_WIDTH  (32),
    .DEPTH      (DEPTH),
    .RESET_PC   (32'h0000_0000),
    .PC_STEP    (4)
  ) dut (
    .clock_in          (clock_in),
    .reset_in          (reset_in),
    .halt_in           (halt_in),
    .redirect_valid_in (redirect_valid_in),
    .redirect_addr_in  (redirect_addr_in),
    .mem_addr_out      (mem_addr_out),
    .mem_read_out      (mem_read_out),
    .mem_valid_in      (mem_valid_in),
    .mem_data_in       (mem_data_in),
    .dec_valid_out     (dec_valid_out),
    .dec_ins_out       (dec_ins_out),
    .dec_pc_out        (dec_pc_out),
    .dec_ready_in      (dec_ready_in),
    .fq_count_out      (fq_count_out)
  );

  always #5 clock_in = ~clock_in;

  int n_checks = 0;
  int n_pass   = 0;
  int n_pops   = 0;

  // Reference model: the in-order list of instructions decode should see.
  ent_t        exp_q[$];
  logic [31:0] exp_pc;
  logic        stale;
  logic        mon_en = 1'b0;

  int          wait_cnt;
  int          fixed_lat;
  int          ready_pct;
  int          halt_pct;
  int          redir_pct;
  logic        force_redir = 1'b0;
  logic [31:0] force_target = '0;

  // Inputs and outputs of the previous cycle, i.e. what the last clock edge acted on.
  logic        p_read, p_valid, p_redir, p_halt;
  logic [31:0] p_addr, p_data, p_raddr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, req, $time);
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_pc   = 32'h0000_0000;
    stale    = 1'b0;
    wait_cnt = -1;
    p_read   = 1'b0;
    p_valid  = 1'b0;
    p_redir  = 1'b0;
    p_halt   = 1'b0;
    p_addr   = '0;
    p_data   = '0;
    p_raddr  = '0;
  endtask

  task automatic idle_inputs();
    halt_in           = 1'b0;
    redirect_valid_in = 1'b0;
    redirect_addr_in  = '0;
    mem_valid_in      = 1'b0;
    mem_data_in       = '0;
    dec_ready_in      = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_read"},  mem_read_out,  1'b0);
    check({tag, "_mem_addr"},  mem_addr_out,  32'h0);
    check({tag, "_dec_valid"}, dec_valid_out, 1'b0);
    check({tag, "_count"},     fq_count_out,  3'd0);
  endtask

  // One clock: account for what the last edge did, check the request line, drive new inputs.
  task automatic step();
    logic was_stale;
    logic exp_read;
    @(posedge clock_in);
    #1;
    was_stale = stale;
    if (p_redir) begin
      exp_q.delete();
      exp_pc = p_raddr;
      stale  = p_read && !p_valid;
    end else if (p_valid) begin
      if (stale) begin
        stale = 1'b0;
      end else begin
        check("resp_addr", p_addr, exp_pc);
        $display("push pc=0x%08h ins=0x%08h", p_addr, p_data);
        exp_q.push_back('{pc: p_addr, ins: p_data});
        exp_pc = exp_pc + 32'd4;
      end
    end

    if (p_read && !p_valid)                   exp_read = 1'b1;
    else if (p_redir || (p_valid && was_stale)) exp_read = 1'b0;
    else                                        exp_read = !p_halt && (exp_q.size() < DEPTH);
    check("mem_read", mem_read_out, exp_read);
    if (mem_read_out && p_read && !p_valid) check("addr_hold", mem_addr_out, p_addr);
    else if (mem_read_out)                  check("req_addr", mem_addr_out, exp_pc);

    mem_valid_in = 1'b0;
    mem_data_in  = $urandom();
    if (mem_read_out) begin
      if (wait_cnt < 0) wait_cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(3));
      if (wait_cnt == 0) begin
        mem_valid_in = 1'b1;
        wait_cnt     = -1;
      end else begin
        wait_cnt--;
      end
    end
    dec_ready_in      = ($urandom_range(99) < ready_pct);
    halt_in           = ($urandom_range(99) < halt_pct);
    redirect_valid_in = !p_redir && ($urandom_range(99) < redir_pct);
    redirect_addr_in  = $urandom() & 32'hFFFF_FFFC;
    if ($urandom_range(3) == 0) redirect_addr_in[31:4] = '1;
    if (force_redir) begin
      redirect_valid_in = 1'b1;
      redirect_addr_in  = force_target;
      force_redir       = 1'b0;
    end

    p_read  = mem_read_out;
    p_valid = mem_valid_in;
    p_redir = redirect_valid_in;
    p_halt  = halt_in;
    p_addr  = mem_addr_out;
    p_data  = mem_data_in;
    p_raddr = redirect_addr_in;
  endtask

  // Monitor: compares the decode head against the model and retires accepted entries.
  initial begin
    forever begin
      @(negedge clock_in);
      if (mon_en && !reset_in) begin
        check("count", fq_count_out, exp_q.size());
        check("dec_valid", dec_valid_out, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
          check("dec_pc", dec_pc_out, exp_q[0].pc);
          check("dec_ins", dec_ins_out, exp_q[0].ins);
          if (dec_valid_out && dec_ready_in && !redirect_valid_in) begin
            $display("pop  pc=0x%08h ins=0x%08h", dec_pc_out, dec_ins_out);
            void'(exp_q.pop_front());
            n_pops++;
          end
        end
      end
    end
  end

  initial begin
    idle_inputs();
    reset_in = 1'b1;
    model_reset();
    repeat (3) @(posedge clock_in);
    #1;
    check_reset_outputs("reset");
    reset_in = 1'b0;
    mon_en   = 1'b1;

    // Decode stalled, fixed memory latency: queue fills to DEPTH then requests stop.
    fixed_lat = 2; ready_pct = 0; halt_pct = 0; redir_pct = 0;
    repeat (30) step();
    check("full_count", fq_count_out, DEPTH);
    check("full_no_req", mem_read_out, 1'b0);

    // Fully random traffic with halts and redirects.
    fixed_lat = -1; ready_pct = 60; halt_pct = 15; redir_pct = 4;
    repeat (2500) step();

    // Reset in the middle of traffic abandons any outstanding request.
    reset_in = 1'b1;
    @(posedge clock_in);
    #1;
    check_reset_outputs("midreset");
    idle_inputs();
    model_reset();
    reset_in = 1'b0;

    // Redirect close to the top of the address space so the fetch PC wraps.
    fixed_lat = -1; ready_pct = 80; halt_pct = 0; redir_pct = 0;
    force_target = 32'hFFFF_FFF4;
    force_redir  = 1'b1;
    repeat (40) step();
    check("wrap_reached", exp_pc < 32'h0000_0100, 1'b1);
    check("pop_activity", n_pops > 100, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
